// File: rtl/cursor_event_ctrl.sv
// Two-cursor controller for the 8x8 grid: queues button events and
// applies them one at a time with edge and no-overlap checks.
module cursor_event_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [5:0]  A_START    = 6'd9,
  parameter logic [5:0]  B_START    = 6'd14,
  parameter logic [31:0] A_KEYS     = {8'd9, 8'd1, 8'd10, 8'd8},
  parameter logic [31:0] B_KEYS     = {8'd12, 8'd4, 8'd13, 8'd11}
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       button_pressed,
  input  logic [7:0] button_index,
  output logic [5:0] a_index,
  output logic [5:0] b_index,
  output logic       moved,
  output logic       blocked,
  output logic [2:0] fifo_level,
  output logic [7:0] drop_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] D_LEFT  = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    COMMIT
  } state_t;

  state_t state, state_d;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic       key_hit;
  logic [2:0] key_ent;
  logic       push_req, full, push, pop;

  logic       ev_sel;
  logic [1:0] ev_dir;
  logic [5:0] tgt_q;

  logic [5:0] cur, oth, tgt;
  logic       at_edge;
  logic       moved_d, blocked_d;

  // Entry format {sel, dir}; later matches win if key tables overlap.
  always_comb begin
    key_hit = 1'b0;
    key_ent = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (button_index == B_KEYS[8*i +: 8]) begin
        key_hit = 1'b1;
        key_ent = {1'b1, 2'(i)};
      end
      if (button_index == A_KEYS[8*i +: 8]) begin
        key_hit = 1'b1;
        key_ent = {1'b0, 2'(i)};
      end
    end
  end

  assign push_req = button_pressed & key_hit;
  assign full     = (level == LW'(FIFO_DEPTH));
  assign push     = push_req & ~full;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= key_ent;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push_req && full && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign fifo_level = 3'(level);

  assign cur = ev_sel ? b_index : a_index;
  assign oth = ev_sel ? a_index : b_index;

  always_comb begin
    at_edge = 1'b0;
    tgt     = cur;
    unique case (ev_dir)
      D_LEFT: begin
        at_edge = (cur[2:0] == 3'd0);
        tgt     = cur - 6'd1;
      end
      D_RIGHT: begin
        at_edge = (cur[2:0] == 3'd7);
        tgt     = cur + 6'd1;
      end
      D_UP: begin
        at_edge = (cur[5:3] == 3'd0);
        tgt     = cur - 6'd8;
      end
      D_DOWN: begin
        at_edge = (cur[5:3] == 3'd7);
        tgt     = cur + 6'd8;
      end
      default: begin
        at_edge = 1'b1;
        tgt     = cur;
      end
    endcase
  end

  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (at_edge || tgt == oth) begin
          blocked_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        moved_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_index <= A_START;
      b_index <= B_START;
      moved   <= 1'b0;
      blocked <= 1'b0;
      ev_sel  <= 1'b0;
      ev_dir  <= 2'd0;
      tgt_q   <= 6'd0;
    end else begin
      moved   <= moved_d;
      blocked <= blocked_d;
      if (pop) {ev_sel, ev_dir} <= mem[rd_ptr];
      if (state == EVAL) tgt_q <= tgt;
      if (state == COMMIT) begin
        if (ev_sel) b_index <= tgt_q;
        else        a_index <= tgt_q;
      end
    end
  end

endmodule

// File: tb/tb_cursor_event_ctrl.sv
// Bench for cursor_event_ctrl: random and directed button traffic,
// scoreboard of expected moved/blocked pulses from a grid-rule model.
module tb_cursor_event_ctrl;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       button_pressed = 1'b0;
  logic [7:0] button_index = 8'd0;
  logic [5:0] a_index, b_index;
  logic       moved, blocked;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  cursor_event_ctrl dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .button_pressed(button_pressed),
    .button_index(button_index),
    .a_index(a_index),
    .b_index(b_index),
    .moved(moved),
    .blocked(blocked),
    .fifo_level(fifo_level),
    .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit mv;
    int at;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   m_q[$];
  int   m_a, m_b, m_drop, m_free;
  int   exp_a, exp_b;
  int   checks = 0;
  int   errors = 0;

  // index = sel*4 + dir, dir: 0 left, 1 right, 2 up, 3 down
  int keys[8] = '{8, 10, 1, 9, 11, 13, 4, 12};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic bit decode(input logic [7:0] c, output int e);
    e = 0;
    for (int i = 0; i < 8; i++)
      if (int'(c) == keys[i]) begin
        e = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_init();
    sb.delete();
    m_q.delete();
    m_a = 9;
    m_b = 14;
    m_drop = 0;
    m_free = 0;
    exp_a = 9;
    exp_b = 14;
  endtask

  // One clock edge of the reference: consumer pops when free, then the
  // new press is queued or dropped against the pre-edge occupancy.
  task automatic model_edge(input bit p, input logic [7:0] c);
    int lvl, e, sel, dir, cur, oth, row, col, t;
    bit v, blk;
    lvl = m_q.size();
    v = decode(c, e);
    if (cyc >= m_free && lvl > 0) begin
      e = m_q.pop_front();
      sel = e / 4;
      dir = e % 4;
      cur = sel ? m_b : m_a;
      oth = sel ? m_a : m_b;
      row = cur / 8;
      col = cur % 8;
      case (dir)
        0: begin blk = (col == 0); t = cur - 1; end
        1: begin blk = (col == 7); t = cur + 1; end
        2: begin blk = (row == 0); t = cur - 8; end
        default: begin blk = (row == 7); t = cur + 8; end
      endcase
      if (!blk && t == oth) blk = 1'b1;
      if (blk) begin
        sb.push_back('{1'b0, cyc + 1, m_a, m_b});
        m_free = cyc + 2;
      end else begin
        if (sel) m_b = t;
        else     m_a = t;
        sb.push_back('{1'b1, cyc + 2, m_a, m_b});
        m_free = cyc + 3;
      end
    end
    if (p && v) begin
      decode(c, e);
      if (lvl == DEPTH) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_q.push_back(e);
      end
    end
  endtask

  task automatic tick(input bit p, input logic [7:0] c);
    @(negedge CLK);
    button_pressed = p;
    button_index = c;
    @(posedge CLK);
    #1;
    model_edge(p, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    button_pressed = 1'b0;
    model_init();
    repeat (2) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    model_edge(1'b0, 8'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        check("rst_a_index", a_index, 9);
        check("rst_b_index", b_index, 14);
        check("rst_moved", moved, 0);
        check("rst_blocked", blocked, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_drop_count", drop_count, 0);
      end else begin
        check("fifo_level", fifo_level, m_q.size());
        check("drop_count", drop_count, m_drop);
        check("pulse_exclusive", int'(moved && blocked), 0);
        if (moved || blocked) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", int'(moved) * 2 + int'(blocked), 0);
          end else begin
            e = sb.pop_front();
            check("pulse_moved", moved, e.mv);
            check("pulse_cycle", cyc, e.at);
            exp_a = e.a;
            exp_b = e.b;
          end
        end else if (sb.size() > 0 && cyc >= sb[0].at) begin
          e = sb.pop_front();
          check("missing_pulse_cycle", cyc + 1, e.at);
          exp_a = e.a;
          exp_b = e.b;
        end
        check("a_index", a_index, exp_a);
        check("b_index", b_index, exp_b);
      end
    end
  end

  initial begin : stim
    int r;
    model_init();
    repeat (3) @(negedge CLK);
    apply_reset();

    // single A right
    tick(1'b1, 8'd10);
    idle(8);
    check("t1_a", a_index, 10);
    check("t1_b", b_index, 14);

    // up twice: second hits row 0
    apply_reset();
    tick(1'b1, 8'd1);
    idle(5);
    tick(1'b1, 8'd1);
    idle(6);
    check("t2_a", a_index, 1);

    // right x5: last collides with B
    apply_reset();
    repeat (5) tick(1'b1, 8'd10);
    idle(20);
    check("t3_a", a_index, 13);
    check("t3_b", b_index, 14);

    // down x8 back to back overflows the queue
    apply_reset();
    repeat (8) tick(1'b1, 8'd9);
    idle(30);
    check("t4_drop", drop_count, 2);
    check("t4_a", a_index, 57);
    check("t4_level", fifo_level, 0);

    // unknown codes and unpressed valid code
    apply_reset();
    tick(1'b1, 8'd0);
    tick(1'b1, 8'd200);
    tick(1'b0, 8'd10);
    idle(6);
    check("t5_level", fifo_level, 0);
    check("t5_a", a_index, 9);
    check("t5_b", b_index, 14);
    check("t5_drop", drop_count, 0);

    // reset while an event sits in EVAL
    apply_reset();
    tick(1'b1, 8'd10);
    tick(1'b0, 8'd0);
    apply_reset();
    idle(6);
    check("t6_a", a_index, 9);
    check("t6_b", b_index, 14);
    check("t6_level", fifo_level, 0);

    // B moves and left edge
    apply_reset();
    tick(1'b1, 8'd12);
    tick(1'b1, 8'd13);
    tick(1'b1, 8'd13);
    idle(12);
    check("t7_b", b_index, 23);
    repeat (3) tick(1'b1, 8'd8);
    idle(12);
    check("t7_a", a_index, 8);

    // random traffic
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) apply_reset();
      r = $urandom_range(0, 99);
      if (r < 55)
        tick(1'b1, 8'(keys[$urandom_range(0, 7)]));
      else if (r < 65)
        tick(1'b1, 8'($urandom_range(0, 255)));
      else
        tick(1'b0, 8'($urandom_range(0, 255)));
    end
    idle(40);
    check("scoreboard_drained", sb.size(), 0);
    check("final_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
